t_chain: RTL and testbench

T_CHAIN -- requirements
Module: t_chain

---
 rtl/t_chain_if.sv | 21 ++
 rtl/t_chain.sv | 148 ++++++++++++++
 tb/tb_t_chain.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t_chain_if.sv
// Matrix stream bundle for t_chain: joint transforms in, accumulated product out.
interface t_chain_if #(
  parameter int WIDTH = 27
);
  logic                             in_valid;
  logic                             in_ready;
  logic [3:0][3:0][WIDTH-1:0]       in_matrix;
  logic                             out_valid;
  logic                             out_ready;
  logic [3:0][3:0][WIDTH-1:0]       out_matrix;

  modport master (
    output in_valid, in_matrix, out_ready,
    input  in_ready, out_valid, out_matrix
  );

  modport slave (
    input  in_valid, in_matrix, out_ready,
    output in_ready, out_valid, out_matrix
  );
endinterface

// File: rtl/t_chain.sv
// Chained 4x4 fixed-point transform product: ACC <= ACC * M for each joint,
// one saturated result element per cycle.
module t_chain #(
  parameter int WIDTH      = 27,
  parameter int FRAC       = 16,
  parameter int MAX_JOINTS = 8,
  localparam int JW        = $clog2(MAX_JOINTS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [JW-1:0] num_joints,
  t_chain_if.slave      bus,
  output logic          busy,
  output logic [JW-1:0] joint_count
);

  typedef logic [3:0][3:0][WIDTH-1:0] mat_t;
  typedef enum logic [1:0] {IDLE, LOAD, MULT, DONE} state_t;

  localparam int SW = 2 * WIDTH + 2;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [SW-1:0] SAT_MAX = {{(WIDTH+3){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(WIDTH+3){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [JW-1:0] MAX_N = JW'(MAX_JOINTS);

  function automatic mat_t identity();
    mat_t m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i][i] = ONE;
    return m;
  endfunction

  state_t        state_q, state_d;
  mat_t          acc_q, acc_d;
  mat_t          m_q, m_d;
  mat_t          r_q, r_d;
  logic [3:0]    k_q, k_d;
  logic [JW-1:0] n_q, n_d;
  logic [JW-1:0] jc_q, jc_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  logic [1:0]                row, col;
  logic signed [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic signed [SW-1:0]      sum, shifted;
  logic [WIDTH-1:0]          elem;

  assign row = k_q[3:2];
  assign col = k_q[1:0];

  // Dot product of ACC row and M column, floored by FRAC, clamped to WIDTH
  always_comb begin
    sum   = '0;
    a_ext = '0;
    b_ext = '0;
    prod  = '0;
    for (int i = 0; i < 4; i++) begin
      a_ext = {{WIDTH{acc_q[row][i][WIDTH-1]}}, acc_q[row][i]};
      b_ext = {{WIDTH{m_q[i][col][WIDTH-1]}}, m_q[i][col]};
      prod  = a_ext * b_ext;
      sum   = sum + {{2{prod[2*WIDTH-1]}}, prod};
    end
    shifted = sum >>> FRAC;
    if (shifted > SAT_MAX)      elem = SAT_MAX[WIDTH-1:0];
    else if (shifted < SAT_MIN) elem = SAT_MIN[WIDTH-1:0];
    else                        elem = shifted[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    r_d     = r_q;
    k_d     = k_q;
    n_d     = n_q;
    jc_d    = jc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = (num_joints > MAX_N) ? MAX_N : num_joints;
          acc_d   = identity();
          jc_d    = '0;
          k_d     = '0;
          state_d = (n_d == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          m_d     = bus.in_matrix;
          k_d     = '0;
          state_d = MULT;
        end
      end
      MULT: begin
        r_d[row][col] = elem;
        k_d           = k_q + 4'd1;
        // R includes the element finished this cycle before it becomes ACC
        if (k_q == 4'd15) begin
          acc_d   = r_d;
          jc_d    = jc_q + 1'b1;
          state_d = (jc_d == n_q) ? DONE : LOAD;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= identity();
      m_q         <= '0;
      r_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      jc_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      m_q         <= m_d;
      r_q         <= r_d;
      k_q         <= k_d;
      n_q         <= n_d;
      jc_q        <= jc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_matrix = acc_q;
  assign busy           = busy_q;
  assign joint_count    = jc_q;

endmodule

// File: tb/tb_t_chain.sv
// Directed bench for t_chain: a transaction-level model of the chain product
// is compared against the DUT every cycle, plus literal pins on key results.
module tb_t_chain;

  localparam int WIDTH      = 27;
  localparam int FRAC       = 16;
  localparam int MAX_JOINTS = 8;
  localparam int JW         = $clog2(MAX_JOINTS + 1);
  localparam longint ONE    = 65536;

  typedef logic [3:0][3:0][WIDTH-1:0] mat_t;
  typedef enum {P_IDLE, P_LOAD, P_MULT, P_DONE} phase_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [JW-1:0] num_joints = '0;
  logic          busy;
  logic [JW-1:0] joint_count;

  t_chain_if #(.WIDTH(WIDTH)) bus();

  t_chain #(.WIDTH(WIDTH), .FRAC(FRAC), .MAX_JOINTS(MAX_JOINTS)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_joints(num_joints),
    .bus(bus),
    .busy(busy),
    .joint_count(joint_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   check_en = 1'b0;
  mat_t stim[16];

  function automatic mat_t ident();
    mat_t m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i][i] = WIDTH'(ONE);
    return m;
  endfunction

  function automatic mat_t diag(longint v);
    mat_t m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i][i] = WIDTH'(v);
    return m;
  endfunction

  function automatic mat_t trans_x(longint x);
    mat_t m;
    m = ident();
    m[0][3] = WIDTH'(x);
    return m;
  endfunction

  function automatic mat_t matmul(mat_t a, mat_t b);
    mat_t   m;
    longint s;
    longint lim;
    lim = longint'(1) <<< (WIDTH - 1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int i = 0; i < 4; i++)
          s += longint'($signed(a[r][i])) * longint'($signed(b[i][c]));
        s = s >>> FRAC;
        if (s > lim - 1) s = lim - 1;
        if (s < -lim)    s = -lim;
        m[r][c] = WIDTH'(s);
      end
    return m;
  endfunction

  // Reference model: what the chain must look like after each clock edge
  phase_t p_phase = P_IDLE;
  int     p_cnt = 0;
  int     p_n = 0;
  int     p_jc = 0;
  mat_t   p_acc;
  mat_t   p_cur;

  always @(posedge clk) begin
    if (reset) begin
      p_phase = P_IDLE;
      p_acc   = ident();
      p_jc    = 0;
      p_cnt   = 0;
    end else begin
      case (p_phase)
        P_IDLE: if (start) begin
          p_n     = (int'(num_joints) > MAX_JOINTS) ? MAX_JOINTS : int'(num_joints);
          p_acc   = ident();
          p_jc    = 0;
          p_phase = (p_n > 0) ? P_LOAD : P_DONE;
        end
        P_LOAD: if (bus.in_valid) begin
          p_cur   = bus.in_matrix;
          p_cnt   = 0;
          p_phase = P_MULT;
        end
        P_MULT: begin
          p_cnt++;
          if (p_cnt == 16) begin
            p_acc   = matmul(p_acc, p_cur);
            p_jc++;
            p_phase = (p_jc == p_n) ? P_DONE : P_LOAD;
          end
        end
        P_DONE: if (bus.out_ready) p_phase = P_IDLE;
        default: p_phase = P_IDLE;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkMatrix(input string name, input mat_t actual, input mat_t expected);
    int bad;
    bad = -1;
    checks++;
    for (int k = 0; k < 16; k++)
      if (bad < 0 && actual[k/4][k%4] !== expected[k/4][k%4]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s element[%0d][%0d] actual=%0d required=%0d at %0t", name,
               bad / 4, bad % 4, $signed(actual[bad/4][bad%4]),
               $signed(expected[bad/4][bad%4]), $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("in_ready", bus.in_ready, p_phase == P_LOAD);
      checkOutput("out_valid", bus.out_valid, p_phase == P_DONE);
      checkOutput("busy", busy, p_phase != P_IDLE);
      checkOutput("joint_count", joint_count, p_jc);
      checkMatrix("out_matrix", bus.out_matrix, p_acc);
    end
  end

  task automatic startChain(input int nj);
    start      = 1'b1;
    num_joints = JW'(nj);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Holds in_valid high and advances through stim[] on each accept
  task automatic applyStimulus(input int nj, input int nmat, output int edges);
    int idx;
    bit rdy;
    idx           = 0;
    bus.in_valid  = (nmat > 0);
    bus.in_matrix = stim[0];
    startChain(nj);
    edges = 1;
    while (bus.out_valid !== 1'b1 && edges < 400) begin
      rdy = bus.in_ready;
      @(negedge clk);
      edges++;
      if (rdy && idx + 1 < nmat) begin
        idx++;
        bus.in_matrix = stim[idx];
      end
    end
    bus.in_valid = 1'b0;
    checkOutput("done_reached", bus.out_valid, 1);
  endtask

  task automatic releaseOut(input int hold, input bit poke_start);
    bus.out_ready = 1'b0;
    repeat (hold) begin
      start      = poke_start;
      num_joints = JW'(3);
      @(negedge clk);
      start = 1'b0;
    end
    bus.out_ready = 1'b1;
    start         = poke_start;
    @(negedge clk);
    bus.out_ready = 1'b0;
    start         = 1'b0;
    checkOutput("back_to_idle", busy, 0);
  endtask

  initial begin
    int edges;
    bus.in_valid  = 1'b0;
    bus.in_matrix = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkMatrix("rst_identity", bus.out_matrix, ident());
    reset = 1'b0;
    @(negedge clk);

    // Empty chain finishes immediately with identity
    startChain(0);
    checkOutput("n0_out_valid", bus.out_valid, 1);
    checkOutput("n0_diag", $signed(bus.out_matrix[2][2]), 65536);
    checkOutput("n0_offdiag", $signed(bus.out_matrix[0][3]), 0);
    releaseOut(0, 1'b0);

    stim[0] = trans_x(196608);
    applyStimulus(1, 1, edges);
    checkOutput("latency_n1", edges, 18);
    checkOutput("n1_tx", $signed(bus.out_matrix[0][3]), 196608);
    releaseOut(1, 1'b0);

    stim[0] = trans_x(65536);
    stim[1] = trans_x(131072);
    applyStimulus(2, 2, edges);
    checkOutput("latency_n2", edges, 35);
    checkOutput("n2_tx", $signed(bus.out_matrix[0][3]), 196608);
    checkOutput("n2_diag", $signed(bus.out_matrix[1][1]), 65536);
    checkOutput("n2_jc", joint_count, 2);
    // Held output with start pokes, then start coinciding with out_ready
    releaseOut(5, 1'b1);

    stim[0] = diag(6553600);
    stim[1] = diag(6553600);
    applyStimulus(2, 2, edges);
    checkOutput("sat_pos", $signed(bus.out_matrix[1][1]), 67108863);
    checkOutput("sat_pos_off", $signed(bus.out_matrix[1][2]), 0);
    releaseOut(2, 1'b0);
    stim[1] = diag(-6553600);
    applyStimulus(2, 2, edges);
    checkOutput("sat_neg", $signed(bus.out_matrix[3][3]), -67108864);
    releaseOut(0, 1'b0);

    // Mixed-sign fractional values exercise floor rounding across three joints
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        stim[0][r][c] = WIDTH'(longint'(r * 4 + c - 7) * 12345 + ((r == c) ? ONE : 0));
        stim[1][r][c] = WIDTH'(longint'(c * 4 - r * 3) * 9001 - 3);
      end
    stim[2] = stim[0];
    applyStimulus(3, 3, edges);
    checkOutput("n3_jc", joint_count, 3);
    releaseOut(1, 1'b0);

    // Oversized request clamps to MAX_JOINTS
    for (int i = 0; i < MAX_JOINTS; i++) stim[i] = trans_x(65536);
    applyStimulus(15, MAX_JOINTS, edges);
    checkOutput("clamp_jc", joint_count, 8);
    checkOutput("clamp_tx", $signed(bus.out_matrix[0][3]), 524288);
    releaseOut(0, 1'b0);

    // Reset in the middle of MULT at k=7, asserted together with start
    stim[0]       = trans_x(196608);
    bus.in_valid  = 1'b1;
    bus.in_matrix = stim[0];
    startChain(1);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("rst_mid_valid", bus.out_valid, 0);
    checkOutput("rst_mid_ready", bus.in_ready, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkMatrix("rst_mid_identity", bus.out_matrix, ident());
    stim[0] = trans_x(-98304);
    applyStimulus(1, 1, edges);
    checkOutput("post_rst_tx", $signed(bus.out_matrix[0][3]), -98304);
    checkOutput("post_rst_latency", edges, 18);
    releaseOut(0, 1'b0);

    repeat (2) @(negedge clk);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
